// File: rtl/capture_ctrl.sv
// capture_ctrl: arm/trigger capture sequencer with a registered output slice on the memory stream
module capture_ctrl #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic [31:0]   cfg_data,
  input  logic          arm,
  input  logic          run,
  input  logic          finish_now,
  input  logic          sti_tvalid,
  output logic          sti_tready,
  input  logic [DW-1:0] sti_tdata,
  output logic          sto_tvalid,
  input  logic          sto_tready,
  output logic          sto_tlast,
  output logic [DW-1:0] sto_tdata,
  output logic          capturing,
  output logic          done,
  output logic [CW-1:0] pre_count
);
  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] delay_q, delay_d, cnt_q, cnt_d, pre_q, pre_d;
  logic          fin_q, fin_d, vld_q, vld_d, last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  logic          acc, fin, end_beat, trig;
  logic          unused_cfg;
  assign unused_cfg = ^cfg_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      delay_q <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      fin_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      fin_q   <= fin_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end
  // A pending or same-cycle finish outranks run, so a trigger never starts once finish is seen
  always_comb begin
    fin      = finish_now || fin_q;
    acc      = sti_tvalid && sti_tready && capturing;
    end_beat = acc && (fin || (state_q == POST && cnt_q == '0));
    trig     = state_q == ARMED && run && !fin;
    state_d  = (!capturing && arm) ? ARMED :
               end_beat            ? DONE  :
               trig                ? POST  : state_q;
  end
  always_comb begin
    capturing  = state_q == ARMED || state_q == POST;
    done       = state_q == DONE;
    sti_tready = !capturing || !vld_q || sto_tready;
    pre_count  = pre_q;
  end
  always_comb begin
    delay_d = cfg_valid ? cfg_data[CW-1:0] : delay_q;
    cnt_d   = trig ? delay_q : (state_q == POST && acc && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    pre_d   = (!capturing && arm) ? '0 :
              (state_q == ARMED && acc && !fin && pre_q != '1) ? pre_q + 1'b1 : pre_q;
    fin_d   = capturing && fin && !end_beat;
    vld_d   = acc ? 1'b1 : sto_tready ? 1'b0 : vld_q;
    last_d  = acc ? end_beat : sto_tready ? 1'b0 : last_q;
    data_d  = acc ? sti_tdata : data_q;
  end
  assign sto_tvalid = vld_q;
  assign sto_tlast  = last_q;
  assign sto_tdata  = data_q;
endmodule
